// File: rtl/spread_ctrl.sv
// ============================================================================
// spread_ctrl
// ----------------------------------------------------------------------------
// Direct-sequence spreading controller. It drives an external 4-stage
// m-sequence generator (seq_en / seq_clr) and spreads a frame of payload bits
// with the chips that come back (seq_data / seq_vld).
//
// Each frame is:
//   * a single reseed pulse (seq_clr)
//   * PRE_BITS unmodulated periods of CHIPS_PER_BIT chips (the preamble)
//   * FRAME_BITS payload bits, each fetched over a valid/ready handshake and
//     XOR-spread over one CHIPS_PER_BIT period
//   * a short gap, then a one-cycle frame_done pulse
//
// The generator answers one cycle after each seq_en. Every issued enable
// therefore carries a tag (phase, bit value, first, last) that is delayed by
// one cycle, so it lines up with the returning chip. A seq_vld that no issued
// enable accounts for finds an empty tag and produces no chip.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active low
//   start       in   single-cycle frame request; only honoured in IDLE
//   busy        out  high from frame acceptance until the return to IDLE
//   bit_in      in   payload bit value
//   bit_vld     in   payload bit valid
//   bit_rdy     out  payload bit ready; only high while waiting for a bit
//   seq_en      out  advance enable to the generator
//   seq_clr     out  reseed pulse to the generator
//   seq_data    in   generator chip, one cycle after seq_en
//   seq_vld     in   generator chip valid
//   chip_out    out  spread chip
//   chip_vld    out  spread chip valid
//   chip_sof    out  first chip of the frame (first preamble chip)
//   chip_eof    out  last chip of the frame (last payload chip)
//   frame_done  out  single-cycle completion pulse, busy drops with it
// ============================================================================
module spread_ctrl #(
    parameter int CHIPS_PER_BIT = 15,
    parameter int PRE_BITS      = 4,
    parameter int FRAME_BITS    = 8,
    parameter int GAP_CYCLES    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    input  logic bit_in,
    input  logic bit_vld,
    output logic bit_rdy,
    output logic seq_en,
    output logic seq_clr,
    input  logic seq_data,
    input  logic seq_vld,
    output logic chip_out,
    output logic chip_vld,
    output logic chip_sof,
    output logic chip_eof,
    output logic frame_done
);

    // ------------------------------------------------------------------------
    // Counter sizing. One phase counter serves the preamble, each payload
    // period and the gap, so it is sized for the longest of the three.
    // ------------------------------------------------------------------------
    localparam int PRE_LEN   = PRE_BITS * CHIPS_PER_BIT;
    // A gap shorter than one cycle cannot separate frame_done from the
    // last chip, so one cycle is the floor.
    localparam int GAP_LEN   = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int CNT_MAX_A = (PRE_LEN > CHIPS_PER_BIT) ? PRE_LEN : CHIPS_PER_BIT;
    localparam int CNT_MAX   = (CNT_MAX_A > GAP_LEN) ? CNT_MAX_A : GAP_LEN;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W     = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] CHIP_LAST = CNT_W'(CHIPS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_PRE    = 3'd2,
        S_BWAIT  = 3'd3,
        S_SPREAD = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    // Preamble chips pass straight through; payload chips are inverted when
    // the bit being spread is a one.
    function automatic logic spread_chip(input logic chip,
                                         input logic payload,
                                         input logic data_bit);
        return chip ^ (payload & data_bit);
    endfunction

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic               r_bit;
    logic               r_busy;
    logic               r_bit_rdy;
    logic               r_seq_en;
    logic               r_seq_clr;
    logic               r_frame_done;

    logic               r_tag_vld_p1;
    logic               r_tag_pay_p1;
    logic               r_tag_bit_p1;
    logic               r_tag_first_p1;
    logic               r_tag_last_p1;

    logic               r_chip_out_p2;
    logic               r_chip_vld_p2;
    logic               r_chip_sof_p2;
    logic               r_chip_eof_p2;

    logic               w_gap_armed;
    logic [CNT_W-1:0]   w_gap_cnt;
    logic               w_tag_first;
    logic               w_tag_last;

    // In GAP the counter stays at zero until the last chip leaves, then
    // counts the cycles after it. Seeing chip_eof restarts the count at 0.
    assign w_gap_armed = r_chip_eof_p2 || (r_cnt != '0);
    assign w_gap_cnt   = r_chip_eof_p2 ? '0 : r_cnt;

    // Tag for the enable being issued this cycle.
    assign w_tag_first = r_seq_en && (r_state == S_PRE) && (r_cnt == '0);
    assign w_tag_last  = r_seq_en && (r_state == S_SPREAD) && (r_cnt == CHIP_LAST)
                         && (r_bit_cnt == BIT_LAST);

    // ------------------------------------------------------------------------
    // Frame sequencer. Every output of this block is a register updated
    // together with the state, so the outputs always match the state that is
    // being entered. r_cnt counts issued enables, never returned chips.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_bit        <= 1'b0;
            r_busy       <= 1'b0;
            r_bit_rdy    <= 1'b0;
            r_seq_en     <= 1'b0;
            r_seq_clr    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_CLR;
                        r_busy    <= 1'b1;
                        r_seq_clr <= 1'b1;
                    end
                end

                S_CLR: begin
                    r_seq_clr <= 1'b0;
                    r_seq_en  <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= S_PRE;
                end

                S_PRE: begin
                    if (r_cnt == PRE_LAST) begin
                        r_cnt     <= '0;
                        r_seq_en  <= 1'b0;
                        r_bit_rdy <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= S_BWAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_BWAIT: begin
                    if (bit_vld && r_bit_rdy) begin
                        r_bit     <= bit_in;
                        r_bit_rdy <= 1'b0;
                        r_seq_en  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_SPREAD;
                    end
                end

                S_SPREAD: begin
                    if (r_cnt == CHIP_LAST) begin
                        r_cnt    <= '0;
                        r_seq_en <= 1'b0;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state <= S_GAP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_bit_rdy <= 1'b1;
                            r_state   <= S_BWAIT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_GAP: begin
                    if (w_gap_armed) begin
                        if (w_gap_cnt == GAP_LAST) begin
                            r_cnt        <= '0;
                            r_bit_cnt    <= '0;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_cnt <= w_gap_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_bit_rdy <= 1'b0;
                    r_seq_en  <= 1'b0;
                    r_seq_clr <= 1'b0;
                end
            endcase
        end
    end

    // ---- stage p1: tag of the issued enable, aligned with seq_vld ----------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tag_vld_p1   <= 1'b0;
            r_tag_pay_p1   <= 1'b0;
            r_tag_bit_p1   <= 1'b0;
            r_tag_first_p1 <= 1'b0;
            r_tag_last_p1  <= 1'b0;
        end else begin
            r_tag_vld_p1   <= r_seq_en;
            r_tag_pay_p1   <= r_seq_en && (r_state == S_SPREAD);
            r_tag_bit_p1   <= r_bit;
            r_tag_first_p1 <= w_tag_first;
            r_tag_last_p1  <= w_tag_last;
        end
    end

    // ---- stage p2: spread chip register ------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_chip_out_p2 <= 1'b0;
            r_chip_vld_p2 <= 1'b0;
            r_chip_sof_p2 <= 1'b0;
            r_chip_eof_p2 <= 1'b0;
        end else if (seq_vld && r_tag_vld_p1) begin
            r_chip_out_p2 <= spread_chip(seq_data, r_tag_pay_p1, r_tag_bit_p1);
            r_chip_vld_p2 <= 1'b1;
            r_chip_sof_p2 <= r_tag_first_p1;
            r_chip_eof_p2 <= r_tag_last_p1;
        end else begin
            r_chip_out_p2 <= 1'b0;
            r_chip_vld_p2 <= 1'b0;
            r_chip_sof_p2 <= 1'b0;
            r_chip_eof_p2 <= 1'b0;
        end
    end

    assign busy       = r_busy;
    assign bit_rdy    = r_bit_rdy;
    assign seq_en     = r_seq_en;
    assign seq_clr    = r_seq_clr;
    assign frame_done = r_frame_done;
    assign chip_out   = r_chip_out_p2;
    assign chip_vld   = r_chip_vld_p2;
    assign chip_sof   = r_chip_sof_p2;
    assign chip_eof   = r_chip_eof_p2;

endmodule

// File: doc/spread_ctrl.md
SPREAD_CTRL -- requirements
Module: spread_ctrl

Interface
REQ-001 SHALL have parameter CHIPS_PER_BIT, default 15, meaning m-sequence chips per bit (one full period of the 4-stage generator).
REQ-002 SHALL have parameter PRE_BITS, default 4, meaning unmodulated preamble periods per frame.
REQ-003 SHALL have parameter FRAME_BITS, default 8, meaning payload bits per frame.
REQ-004 SHALL have parameter GAP_CYCLES, default 2, meaning idle cycles after the last chip before frame_done.
REQ-005 SHALL have port clk  in  1  the single clock, with all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-007 SHALL have port start  in  1  single-cycle frame request.
REQ-008 SHALL have port busy  out  1  high from frame acceptance until return to IDLE.
REQ-009 SHALL have ports bit_in  in  1, bit_vld  in  1 and bit_rdy  out  1, forming the payload bit handshake.
REQ-010 SHALL have port seq_en  out  1  advance enable to the m-sequence generator.
REQ-011 SHALL have port seq_clr  out  1  active-high reseed pulse to the generator.
REQ-012 SHALL have ports seq_data  in  1 and seq_vld  in  1, carrying the generator chip and its valid, which arrive one cycle after seq_en.
REQ-013 SHALL have port chip_out  out  1  spread chip.
REQ-014 SHALL have port chip_vld  out  1  chip valid.
REQ-015 SHALL have ports chip_sof  out  1 and chip_eof  out  1, which flag the first and last chip of a frame.
REQ-016 SHALL have port frame_done  out  1  single-cycle completion pulse.

Function
REQ-017 SHALL implement the states IDLE, CLR, PRE, BWAIT, SPREAD and GAP.
REQ-018 IDLE: on start=1, SHALL go to CLR and raise busy; start in any other state SHALL be ignored.
REQ-019 CLR: SHALL assert seq_clr for exactly one cycle with seq_en=0, then go to PRE.
REQ-020 PRE: SHALL assert seq_en every cycle for exactly PRE_BITS*CHIPS_PER_BIT cycles, then go to BWAIT.
REQ-021 BWAIT: SHALL assert bit_rdy; on bit_vld&bit_rdy it SHALL latch bit_in and go to SPREAD; seq_en SHALL be 0 while waiting.
REQ-022 SPREAD: SHALL assert seq_en for exactly CHIPS_PER_BIT cycles; after that, SHALL go to BWAIT if fewer than FRAME_BITS bits have been sent, else to GAP.
REQ-023 GAP: SHALL wait GAP_CYCLES cycles counted after the final chip_vld, pulse frame_done for 1 cycle, then go to IDLE with busy=0 in the same cycle.
REQ-024 SHALL count issued seq_en cycles, not seq_vld, for phase length; counters SHALL be sized by $clog2 of the maximum count.
REQ-025 SHALL delay a tag (phase, latched bit, first, last) by 1 cycle so it aligns with seq_vld.
REQ-026 On seq_vld=1, SHALL register on the next cycle: chip_vld=1 and chip_out=seq_data during preamble, or chip_out=seq_data^bit during payload.
REQ-027 chip_sof SHALL be 1 only with the first preamble chip; chip_eof SHALL be 1 only with the last payload chip.
REQ-028 seq_vld with no matching issued enable SHALL be ignored and SHALL produce no chip.
REQ-029 Total chip_vld pulses per frame SHALL be (PRE_BITS+FRAME_BITS)*CHIPS_PER_BIT, with no loss or duplication under any bit_vld stall pattern.
REQ-030 bit_rdy SHALL be 0 outside BWAIT; a bit_vld outside BWAIT SHALL NOT be consumed.

Reset
REQ-031 While rst=0 at a clock edge: state SHALL be IDLE; busy, bit_rdy, seq_en, seq_clr, chip_out, chip_vld, chip_sof, chip_eof and frame_done SHALL be 0; all counters and the tag SHALL be 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no further chip_vld and no frame_done; a later start SHALL produce a complete frame.

Verification
REQ-033 Reset: hold rst=0 for 3 cycles with random inputs -> all outputs 0 each cycle after the first edge.
REQ-034 Nominal frame: defaults, generator seed 4'b1000, bit_vld always 1, payload 10110010 -> 180 chip_vld; first 15 chips 0,0,0,1,1,1,1,0,1,0,1,1,0,0,1 with chip_sof on chip 1; each payload bit of value 1 inverts its 15-chip period; chip_eof on chip 180; frame_done exactly 2 cycles after the last chip_vld cycle.
REQ-035 Stall: drop bit_vld for 5 cycles before payload bit 3 -> seq_en=0 and chip_vld=0 throughout the stall; the chip stream after resumption is identical to the unstalled run; 180 chips total.
REQ-036 Busy start: pulse start during PRE and again during SPREAD -> no seq_clr, counters unchanged, single frame of 180 chips.
REQ-037 Abort: rst=0 for 1 cycle at payload chip 40 -> next cycle all outputs 0 and IDLE; a new start yields seq_clr, then chip_sof and 180 chips.
REQ-038 Spurious valid: seq_vld=1 injected in IDLE and BWAIT -> no chip_vld, counts unchanged.
